// File: rtl/abl_seq.sv
// Address-bus-low addressing-mode sequencer: steps operand fetch, effective address and PC restore.
// Build option: define ABL_PAGE_FIXUP_EN to resolve page carries in a dedicated FIXUP cycle.
module abl_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       taken,
  input  logic       rdy,
  input  logic       CO,
  output logic [2:0] op,
  output logic       CI,
  output logic       ld_ahl,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic [1:0] reg_sel,
  output logic       abh_inc,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPER    = 3'd1,
    S_OPER_HI = 3'd2,
    S_EA      = 3'd3,
    S_BR_EA   = 3'd4,
    S_STACK   = 3'd5,
    S_FIXUP   = 3'd6,
    S_RESTORE = 3'd7
  } state_t;

  state_t     r_state;
  logic [2:0] r_mode;

  logic w_indexed;
  logic w_ea_fix;
  logic w_br_fix;
  logic w_ld_ahl, w_ld_pc, w_inc_pc, w_abh_inc, w_done, w_err;

  // Only the absolute indexed modes can cross a page; ZPX wraps inside page 0.
  assign w_indexed = (r_mode == 3'd3) || (r_mode == 3'd4);

`ifdef ABL_PAGE_FIXUP_EN
  assign w_ea_fix = w_indexed & CO;
  assign w_br_fix = taken & CO;
`else
  assign w_ea_fix = 1'b0;
  assign w_br_fix = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 3'd0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            case (mode)
              3'd6:    r_state <= S_STACK;
              3'd7:    r_state <= S_RESTORE;
              default: r_state <= S_OPER;
            endcase
          end
        end
        S_OPER: begin
          case (r_mode)
            3'd0, 3'd1: r_state <= S_EA;
            3'd5:       r_state <= S_BR_EA;
            default:    r_state <= S_OPER_HI;
          endcase
        end
        S_OPER_HI: r_state <= S_EA;
        S_EA:      r_state <= w_ea_fix ? S_FIXUP : S_RESTORE;
        S_BR_EA:   r_state <= w_br_fix ? S_FIXUP : S_RESTORE;
        S_STACK:   r_state <= S_RESTORE;
        S_FIXUP:   r_state <= S_RESTORE;
        S_RESTORE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    op        = 3'b110;
    CI        = 1'b0;
    reg_sel   = 2'b00;
    w_ld_ahl  = 1'b0;
    w_ld_pc   = 1'b0;
    w_inc_pc  = 1'b0;
    w_abh_inc = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      S_OPER: begin
        CI       = 1'b1;
        w_ld_pc  = 1'b1;
        w_inc_pc = 1'b1;
      end
      S_OPER_HI: begin
        CI       = 1'b1;
        w_ld_pc  = 1'b1;
        w_inc_pc = 1'b1;
        w_ld_ahl = 1'b1;
      end
      S_EA: begin
        op = (r_mode <= 3'd1) ? 3'b011 : 3'b111;
        case (r_mode)
          3'd1, 3'd3: reg_sel = 2'b01;
          3'd4:       reg_sel = 2'b10;
          default:    reg_sel = 2'b00;
        endcase
`ifndef ABL_PAGE_FIXUP_EN
        w_abh_inc = w_indexed & CO;
`endif
      end
      S_BR_EA: begin
        w_ld_pc = 1'b1;
        if (taken) begin
          op = 3'b010;
`ifndef ABL_PAGE_FIXUP_EN
          w_abh_inc = CO;
`endif
        end else begin
          CI       = 1'b1;
          w_inc_pc = 1'b1;
        end
      end
      S_STACK: begin
        op      = 3'b001;
        reg_sel = 2'b11;
      end
      S_FIXUP: w_abh_inc = 1'b1;
      S_RESTORE: begin
        op     = 3'b000;
        w_done = 1'b1;
        w_err  = (r_mode == 3'd7);
      end
      default: ;
    endcase
  end

  // A stalled bus must not see any one-shot strobe; op/CI/reg_sel stay steady.
  assign ld_ahl      = w_ld_ahl  & rdy;
  assign ld_pc       = w_ld_pc   & rdy;
  assign inc_pc      = w_inc_pc  & rdy;
  assign abh_inc     = w_abh_inc & rdy;
  assign done        = w_done    & rdy;
  assign err         = w_err     & rdy;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_abl_seq.sv
// Bench for abl_seq: queue-of-steps reference model compared every cycle, plus directed latency checks.
module tb_abl_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, taken, rdy, co;
  logic [2:0] mode;
  logic [2:0] op, dbg_state;
  logic       CI, ld_ahl, ld_pc, inc_pc, abh_inc, busy, done, err;
  logic [1:0] reg_sel;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

`ifdef ABL_PAGE_FIXUP_EN
  localparam bit FIX_EN = 1'b1;
`else
  localparam bit FIX_EN = 1'b0;
`endif

  localparam int P_OPER = 1, P_OPER_HI = 2, P_EA = 3, P_BR = 4, P_STACK = 5, P_FIX = 6, P_RESTORE = 7;

  abl_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .taken(taken), .rdy(rdy), .CO(co),
    .op(op), .CI(CI), .ld_ahl(ld_ahl), .ld_pc(ld_pc), .inc_pc(inc_pc), .reg_sel(reg_sel),
    .abh_inc(abh_inc), .busy(busy), .done(done), .err(err), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // {op[12:10], CI[9], ld_ahl[8], ld_pc[7], inc_pc[6], reg_sel[5:4], abh_inc[3], busy[2], done[1], err[0]}
  wire [12:0] dut_v = {op, CI, ld_ahl, ld_pc, inc_pc, reg_sel, abh_inc, busy, done, err};

  // Reference model: the remaining phases of the current sequence as a queue.
  int         mq[$];
  logic [2:0] mm = 3'd0;

  always @(posedge clk) begin
    int cur;
    if (!rst_n) begin
      mq.delete();
    end else if (rdy) begin
      if (mq.size() == 0) begin
        if (start) begin
          mm = mode;
          case (mode)
            3'd0, 3'd1:       mq = '{P_OPER, P_EA, P_RESTORE};
            3'd2, 3'd3, 3'd4: mq = '{P_OPER, P_OPER_HI, P_EA, P_RESTORE};
            3'd5:             mq = '{P_OPER, P_BR, P_RESTORE};
            3'd6:             mq = '{P_STACK, P_RESTORE};
            default:          mq = '{P_RESTORE};
          endcase
        end
      end else begin
        cur = mq.pop_front();
        if (FIX_EN && cur == P_EA && co && (mm == 3'd3 || mm == 3'd4)) mq.push_front(P_FIX);
        if (FIX_EN && cur == P_BR && co && taken) mq.push_front(P_FIX);
      end
    end
  end

  function automatic logic [12:0] model_out();
    logic [2:0] e_op = 3'b110;
    logic e_ci = 0, e_ahl = 0, e_pc = 0, e_inc = 0, e_abh = 0, e_done = 0, e_err = 0;
    logic [1:0] e_rs = 2'b00;
    bit idx = (mm == 3'd3 || mm == 3'd4);
    if (mq.size() != 0) begin
      case (mq[0])
        P_OPER:    begin e_ci = 1; e_pc = 1; e_inc = 1; end
        P_OPER_HI: begin e_ci = 1; e_pc = 1; e_inc = 1; e_ahl = 1; end
        P_EA: begin
          e_op  = (mm == 3'd0 || mm == 3'd1) ? 3'b011 : 3'b111;
          e_rs  = (mm == 3'd1 || mm == 3'd3) ? 2'b01 : (mm == 3'd4) ? 2'b10 : 2'b00;
          e_abh = !FIX_EN && idx && co;
        end
        P_BR: begin
          e_pc = 1;
          if (taken) begin e_op = 3'b010; e_abh = !FIX_EN && co; end
          else begin e_ci = 1; e_inc = 1; end
        end
        P_STACK:   begin e_op = 3'b001; e_rs = 2'b11; end
        P_FIX:     e_abh = 1;
        default:   begin e_op = 3'b000; e_done = 1; e_err = (mm == 3'd7); end
      endcase
    end
    return {e_op, e_ci, e_ahl & rdy, e_pc & rdy, e_inc & rdy, e_rs, e_abh & rdy,
            mq.size() != 0, e_done & rdy, e_err & rdy};
  endfunction

  always @(negedge clk) begin
    logic [12:0] e;
    if (chk_en) begin
      e = model_out();
      checks++;
      if (dut_v !== e) begin
        errors++;
        $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, dut_v, e);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic s, input logic [2:0] m, input logic t, input logic r,
                      input logic c, input logic rn);
    @(posedge clk);
    #1;
    start = s; mode = m; taken = t; rdy = r; co = c; rst_n = rn;
  endtask

  logic [12:0] cap[16];

  // Launch one sequence, optionally stall, and return the cycle on which done appears.
  task automatic run_txn(input logic [2:0] m, input logic t, input logic c,
                         input int stall_at, input int stall_len, output int lat);
    logic r;
    tick(1, m, t, 1, c, 1);
    lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      r = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
      tick(0, m, t, r, c, 1);
      #1;
      cap[n] = dut_v;
      if (dut_v[1]) lat = n;
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout mode=%0d got=no_done exp=done", m);
    end
  endtask

  initial begin
    int lat;
    start = 0; mode = 0; taken = 0; rdy = 1; co = 0; rst_n = 0;
    tick(0, 0, 0, 1, 0, 0);
    chk_en = 1'b1;
    tick(0, 0, 0, 1, 0, 1);
    #1 chk("reset_vec", dut_v, 13'h1800);

    // Reset in OPER_HI
    tick(1, 3'd2, 0, 1, 0, 1);
    tick(0, 3'd2, 0, 1, 0, 1);
    tick(0, 3'd2, 0, 1, 0, 0);
    #1 chk("oper_hi_ld_ahl", ld_ahl, 1);
    tick(0, 3'd2, 0, 1, 0, 1);
    #1 chk("mid_reset_vec", dut_v, 13'h1800);

    run_txn(3'd2, 0, 0, 0, 0, lat);
    chk("abs_lat", lat, 4);
    chk("abs_ahl_c2", cap[2][8], 1);
    chk("abs_ahl_c3", cap[3][8], 0);
    chk("abs_ea_op", cap[3][12:10], 3'b111);

    run_txn(3'd3, 0, 1, 0, 0, lat);
    chk("absx_co_lat", lat, FIX_EN ? 5 : 4);
    chk("absx_co_abh", FIX_EN ? cap[4][3] : cap[3][3], 1);
    chk("absx_ea_rs", cap[3][5:4], 2'b01);

    run_txn(3'd5, 1, 0, 0, 0, lat);
    chk("br_t_lat", lat, 3);
    chk("br_t_op", cap[2][12:10], 3'b010);
    chk("br_t_pc", cap[2][7], 1);
    chk("br_t_inc", cap[2][6], 0);

    run_txn(3'd5, 0, 0, 0, 0, lat);
    chk("br_nt_op_ci", {cap[2][12:10], cap[2][9]}, 4'b1101);
    chk("br_nt_inc", cap[2][6], 1);

    run_txn(3'd1, 0, 1, 0, 0, lat);
    chk("zpx_lat", lat, 3);
    chk("zpx_rs", cap[2][5:4], 2'b01);
    chk("zpx_abh", cap[2][3], 0);

    run_txn(3'd0, 0, 0, 1, 2, lat);
    chk("stall_lat", lat, 5);
    chk("stall_ld_pc", cap[1][7], 0);
    chk("stall_op", cap[2][12:10], 3'b110);
    chk("post_stall_ld_pc", cap[3][7], 1);

    run_txn(3'd6, 0, 0, 0, 0, lat);
    chk("stack_lat", lat, 2);
    chk("stack_op_rs", {cap[1][12:10], cap[1][5:4]}, 5'b00111);

    run_txn(3'd7, 0, 0, 0, 0, lat);
    chk("rsv_lat", lat, 1);
    chk("rsv_err_done", {cap[1][1], cap[1][0]}, 2'b11);

    // start during RESTORE is ignored
    tick(1, 3'd7, 0, 1, 0, 1);
    tick(1, 3'd2, 0, 1, 0, 1);
    tick(0, 3'd2, 0, 1, 0, 1);
    #1 chk("restore_start_ign", busy, 0);

    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 99) != 0);
    end
    tick(0, 0, 0, 1, 0, 1);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
